mem_arbiter: RTL

- Single-port RAM arbiter between the fetch path (instruction read) and the MEM-stage data path (load/store) of the 5-stage pipeline.
- Grants one requester at a time, drives the RAM port, and holds each requester's wait flag until the RAM reports ACCESS.
- Data has priority. A streak limiter prevents fetch starvation. A watchdog turns a hung access into an error completion.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/arb_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline memory subsystem: RAM handshake states,
// arbiter FSM states and the native machine word.
package cpu_types_pkg;

  // Status reported by the RAM model each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter ownership of the single RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/arb_watchdog.sv
// Service-time watchdog for the memory arbiter. Counts cycles while an access
// stays in service and flags the cycle in which the budget is used up.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic run,      // in a service state and staying there next cycle
  output logic expired   // this is the last allowed service cycle
);

  logic [7:0] timer_q, timer_d;

  // Count while the access continues; any exit to IDLE clears the count.
  always_comb begin
    timer_d = run ? timer_q + 8'd1 : 8'd0;
  end

  // Timer register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired = (timer_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM-stage data
// path. Data has priority, a streak limiter guarantees fetch progress, and a
// watchdog converts a hung access into an error completion.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  // fetch port
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ierr,
  // data port
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              derr,
  // RAM port
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  arb_state_t state_q, state_d;
  logic [3:0] streak_q, streak_d;
  ramstate_t  rs;
  logic       expired;
  logic       run;
  logic       done;
  logic       bad;

  assign rs = ramstate_t'(ramstate);

  // A timed-out access completes as an error unless the RAM answers that cycle.
  assign done = (rs == ACCESS) || (rs == ERROR) || expired;
  assign bad  = (rs == ERROR) || ((rs != ACCESS) && expired);
  assign run  = (state_q != IDLE) && (state_d == state_q);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .run    (run),
    .expired(expired)
  );

  // State and streak registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Grant decision, RAM port steering and requester handshake outputs.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ierr     = 1'b0;
    derr     = 1'b0;
    iload    = '0;
    dload    = '0;

    unique case (state_q)
      IDLE: begin
        // Data wins ties unless it has already starved a waiting fetch.
        if ((dREN || dWEN) && !(iREN && (streak_q == MaxStreak))) begin
          state_d = DSERV;
          if (!iREN) begin
            streak_d = 4'd0;
          end else if (streak_q != MaxStreak) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (iREN) begin
          state_d  = ISERV;
          streak_d = 4'd0;
        end
      end

      ISERV: begin
        ramaddr = iaddr;
        if (!iREN) begin
          // Fetch withdrawn (flush): release the RAM without a handshake.
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (done) begin
            iwait   = 1'b0;
            ierr    = bad;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end

      DSERV: begin
        // Live pass-through: the MEM stage holds its operands while waiting.
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (done) begin
          dwait   = 1'b0;
          derr    = bad;
          dload   = ramload;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
